// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers.
package pipe_pkg;

    localparam int unsigned LEVEL_W = 2;

    // Fill bit for the default FLUSH_VAL of any stage width.
    localparam logic FLUSH_FILL = 1'b0;

    // Encodings equal the number of held entries, so level is the state itself.
    typedef enum logic [LEVEL_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

endpackage

// File: rtl/elastic_stage_reg.sv
// Width-configurable pipeline stage register with valid/ready handshake,
// freeze/flush control and an optional two-entry skid buffer.
module elastic_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       SKID      = 1,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{FLUSH_FILL}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [LEVEL_W-1:0] level
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q;
    logic                in_fire, out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign level     = state_q;
    assign out_fire  = out_valid & out_ready & ~freeze;
    assign in_fire   = in_valid & in_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic skid_load;

            // Ready depends only on the state flop, cutting the out_ready path.
            assign in_ready  = (state_q != ST_SKID) & ~freeze & ~flush;
            assign skid_load = (state_q == ST_FULL) & in_fire & ~out_fire;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q <= FLUSH_VAL;
                end else if (skid_load) begin
                    skid_q <= in_data;
                end
            end
        end else begin : g_noskid
            assign in_ready = ((state_q == ST_EMPTY) | out_ready) & ~freeze & ~flush;
            assign skid_q   = FLUSH_VAL;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
        end else if (!freeze) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d = ST_SKID;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = FLUSH_VAL;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = FLUSH_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= FLUSH_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

endmodule
